// File: rtl/channel_scanner.sv
// Round-robin channel scanner driving a 3-to-8 decoder select, with per-channel dwell.
// Define CHANNEL_SCANNER_SKIP_EN to honour ch_mask; otherwise all 8 channels are scanned.
module channel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         ch_mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               step,
    output logic               done
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx, dwell_q, dwell_q_nx;
    logic               mode_q, mode_q_nx;
    logic [2:0]         sel_nx;
    logic               sel_valid_nx, busy_nx, step_nx, done_nx;
    logic [7:0]         en;
    logic               lo_any, nx_any;
    logic [2:0]         lo_idx, nx_idx;

`ifdef CHANNEL_SCANNER_SKIP_EN
    assign en = ch_mask;
`else
    assign en = 8'hFF;
`endif

    // Lowest enabled channel overall, and lowest enabled channel strictly above sel.
    always_comb begin
        lo_any = 1'b0;
        lo_idx = 3'd0;
        nx_any = 1'b0;
        nx_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i]) begin
                lo_any = 1'b1;
                lo_idx = 3'(i);
                if (i > int'(sel)) begin
                    nx_any = 1'b1;
                    nx_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        sel_valid_nx = sel_valid;
        busy_nx      = busy;
        step_nx      = 1'b0;
        done_nx      = 1'b0;
        cnt_nx       = cnt;
        mode_q_nx    = mode_q;
        dwell_q_nx   = dwell_q;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    mode_q_nx  = mode;
                    dwell_q_nx = dwell;
                    if (lo_any) begin
                        state_nx     = SCAN;
                        sel_nx       = lo_idx;
                        sel_valid_nx = 1'b1;
                        busy_nx      = 1'b1;
                        step_nx      = 1'b1;
                        cnt_nx       = dwell;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nx     = IDLE;
                    sel_valid_nx = 1'b0;
                    busy_nx      = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - DWELL_W'(1);
                end else if (nx_any) begin
                    sel_nx  = nx_idx;
                    step_nx = 1'b1;
                    cnt_nx  = dwell_q;
                end else if (mode_q && lo_any) begin
                    // Wrap straight to the lowest channel: no idle gap cycle.
                    sel_nx  = lo_idx;
                    step_nx = 1'b1;
                    cnt_nx  = dwell_q;
                end else begin
                    state_nx     = IDLE;
                    sel_valid_nx = 1'b0;
                    busy_nx      = 1'b0;
                    done_nx      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            dwell_q   <= '0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            sel_valid <= sel_valid_nx;
            busy      <= busy_nx;
            step      <= step_nx;
            done      <= done_nx;
            cnt       <= cnt_nx;
            mode_q    <= mode_q_nx;
            dwell_q   <= dwell_q_nx;
        end
    end

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner; expectations follow CHANNEL_SCANNER_SKIP_EN if defined.
module tb_channel_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] ch_mask = 8'h00;
    logic [2:0] sel;
    logic       sel_valid, busy, step, done;

    int tests = 0;
    int fails = 0;

    channel_scanner #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .ch_mask(ch_mask), .sel(sel), .sel_valid(sel_valid),
        .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int steps;
        int exp_sel;
        int seq_skip [3] = '{2, 5, 7};

        // Reset state
        #12;
        check("rst_sel", 32'(sel), 0);
        check("rst_valid", 32'(sel_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_step", 32'(step), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

        // Single pass, all channels, dwell=2
        ch_mask = 8'hFF; dwell = 8'd2; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        steps = 0;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 3; k++) begin
                check("sp_sel", 32'(sel), 32'(ch));
                check("sp_busy", 32'(busy), 1);
                check("sp_valid", 32'(sel_valid), 1);
                check("sp_step", 32'(step), 32'(k == 0));
                check("sp_done", 32'(done), 0);
                if (step) steps++;
                tick();
            end
        end
        check("sp_steps", 32'(steps), 8);
        check("sp_end_busy", 32'(busy), 0);
        check("sp_end_valid", 32'(sel_valid), 0);
        check("sp_end_done", 32'(done), 1);
        check("sp_end_sel", 32'(sel), 7);
        tick();
        check("sp_done_once", 32'(done), 0);

        // Skip pattern, continuous, dwell=0
        ch_mask = 8'b1010_0100; dwell = 8'd0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 12; n++) begin
`ifdef CHANNEL_SCANNER_SKIP_EN
            exp_sel = seq_skip[n % 3];
`else
            exp_sel = n % 8;
`endif
            check("skip_sel", 32'(sel), 32'(exp_sel));
            check("skip_step", 32'(step), 1);
            check("skip_busy", 32'(busy), 1);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("skip_stop_busy", 32'(busy), 0);

        // Empty mask
        ch_mask = 8'h00; dwell = 8'd1; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef CHANNEL_SCANNER_SKIP_EN
        check("empty_busy", 32'(busy), 0);
        check("empty_done", 32'(done), 1);
        check("empty_step", 32'(step), 0);
        tick();
        check("empty_done_once", 32'(done), 0);
        check("empty_busy2", 32'(busy), 0);
`else
        check("nomask_busy", 32'(busy), 1);
        check("nomask_sel", 32'(sel), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        // Stop during channel 4, continuous, dwell=3
        ch_mask = 8'hFF; dwell = 8'd3; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("stop_pre_sel", 32'(sel), 4);
        check("stop_pre_step", 32'(step), 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_valid", 32'(sel_valid), 0);
        check("stop_sel", 32'(sel), 4);
        check("stop_done", 32'(done), 0);
        tick();
        check("stop_done2", 32'(done), 0);
        check("stop_sel_hold", 32'(sel), 4);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 0);
        check("ss_valid", 32'(sel_valid), 0);
        check("ss_done", 32'(done), 0);
        check("ss_step", 32'(step), 0);

        // start during SCAN is ignored
        ch_mask = 8'hFF; dwell = 8'd1; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rs_sel1", 32'(sel), 1);
        check("rs_step1", 32'(step), 1);
        start = 1'b1; dwell = 8'd5; mode = 1'b1;
        tick();
        start = 1'b0;
        check("rs_sel_hold", 32'(sel), 1);
        check("rs_no_step", 32'(step), 0);
        tick();
        check("rs_sel2", 32'(sel), 2);
        check("rs_step2", 32'(step), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Asynchronous reset mid-scan
        ch_mask = 8'h30; dwell = 8'd0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ar_pre_busy", 32'(busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_valid", 32'(sel_valid), 0);
        check("ar_sel", 32'(sel), 0);
        check("ar_step", 32'(step), 0);
        check("ar_done", 32'(done), 0);
        #7 rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef CHANNEL_SCANNER_SKIP_EN
        check("ar_restart_sel", 32'(sel), 4);
`else
        check("ar_restart_sel", 32'(sel), 0);
`endif
        check("ar_restart_busy", 32'(busy), 1);
        check("ar_restart_step", 32'(step), 1);
        check("ar_restart_done", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 SHALL have parameter: DWELL_W, 8, width of the dwell-count input.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a scan.
REQ-005 SHALL have port: stop  input  1  abort the current scan.
REQ-006 SHALL have port: mode  input  1  0 = single pass, 1 = continuous; sampled at start.
REQ-007 SHALL have port: dwell  input  DWELL_W  each channel is held for dwell+1 cycles; sampled at start.
REQ-008 SHALL have port: ch_mask  input  8  bit i = 1 enables channel i; sampled live at every channel select.
REQ-009 SHALL have port: sel  output  3  registered channel index, drives the 3-to-8 decoder select input.
REQ-010 SHALL have port: sel_valid  output  1  sel is an active channel.
REQ-011 SHALL have port: busy  output  1  scan in progress.
REQ-012 SHALL have port: step  output  1  one-cycle pulse in the first cycle of each new sel value.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at normal end of a scan.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, SCAN.
REQ-015 In IDLE, start=1 and stop=0 SHALL latch mode and dwell and select the lowest enabled channel; the next cycle shows busy=1, sel_valid=1, step=1 and sel set to that channel.
REQ-016 A start in IDLE with no enabled channel SHALL keep the FSM in IDLE and pulse done for one cycle in the next cycle, with busy=0.
REQ-017 In SCAN, a down-counter loaded with the latched dwell SHALL decrement every cycle; when it reaches 0 the scanner SHALL advance to the next enabled channel above sel and reload the counter.
REQ-018 Each channel SHALL be presented for exactly dwell+1 cycles; dwell=0 gives one cycle per channel.
REQ-019 Continuous mode SHALL wrap from the highest enabled channel to the lowest enabled channel, with no gap cycle.
REQ-020 Single-pass mode SHALL end after the highest enabled channel's dwell; the next cycle SHALL show busy=0, sel_valid=0 and done=1 for exactly one cycle.
REQ-021 If no channel is enabled at an advance point in either mode, the scan SHALL end as in REQ-020 (done pulse).
REQ-022 stop=1 in SCAN SHALL return the FSM to IDLE on the next cycle with busy=0 and sel_valid=0; no done pulse is produced.
REQ-023 start=1 and stop=1 in the same cycle SHALL be treated as stop only; start during SCAN SHALL be ignored.
REQ-024 sel SHALL hold its last value while in IDLE; step and done SHALL never be asserted in the same cycle.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force IDLE, sel=0, sel_valid=0, busy=0, step=0, done=0, dwell counter=0 and the latched mode and dwell to 0.
REQ-026 Reset asserted mid-scan SHALL abort the scan immediately with no done pulse; after release, the first start behaves as REQ-015.

Configuration
REQ-027 The macro CHANNEL_SCANNER_SKIP_EN SHALL control the masked-skip feature.
REQ-028 With CHANNEL_SCANNER_SKIP_EN defined, ch_mask SHALL be honoured as in REQ-008 and REQ-015 to REQ-021.
REQ-029 With CHANNEL_SCANNER_SKIP_EN undefined, ch_mask SHALL be ignored and all 8 channels scanned in order 0..7; the port SHALL remain present.

Verification
REQ-030 Bench SHALL check single pass: mask=8'hFF, dwell=2, mode=0, start -> sel 0..7, each for 3 cycles, 8 step pulses, done one cycle after 24 busy cycles.
REQ-031 Bench SHALL check skip: mask=8'b1010_0100, dwell=0, mode=1 -> sel sequence 2,5,7,2,5,7,... with no gap cycles (with the macro defined); undefined -> sel 0..7 repeating.
REQ-032 Bench SHALL check empty mask: mask=0, start -> busy stays 0, done=1 one cycle later (macro defined).
REQ-033 Bench SHALL check stop: continuous, dwell=3, stop during channel 4 -> next cycle busy=0, sel_valid=0, sel holds 4, no done.
REQ-034 Bench SHALL check simultaneous start+stop in IDLE -> no scan; start during SCAN -> no restart, sequence unchanged.
REQ-035 Bench SHALL check reset: rst_n low mid-scan for a non-clock-aligned interval -> outputs 0 immediately; a new start then begins at the lowest enabled channel.
